// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: shared constants for the time-of-day controller.
// Contents: field widths and limits, LED bus width, mode codes and a
// wrapping field-increment helper used by the controller.
package timekeeper_pkg;

    localparam int unsigned FIELD_W = 6;
    localparam int unsigned LED_W   = 18;

    localparam logic [FIELD_W-1:0] SEC_MAX  = 6'd59;
    localparam logic [FIELD_W-1:0] MIN_MAX  = 6'd59;
    localparam logic [FIELD_W-1:0] HOUR_MAX = 6'd23;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_RUN      = 2'd0;
    localparam mode_t MODE_SET_SEC  = 2'd1;
    localparam mode_t MODE_SET_MIN  = 2'd2;
    localparam mode_t MODE_SET_HOUR = 2'd3;

    // Add one, returning to zero once the field limit has been reached.
    function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] value,
                                                    input logic [FIELD_W-1:0] max_value);
        return (value >= max_value) ? '0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/timekeeper_ctrl_button_conditioner.sv
// button_conditioner: conditions one raw push-button input.
// Two-flop synchronizer, then a debouncer that accepts a level change only
// after DEBOUNCE_CYCLES consecutive synchronized samples differ from the
// current debounced level. Emits a one-cycle pulse on an accepted 0->1.
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   raw           raw button level, asynchronous to clock
//   pulse         one-cycle pulse on debounced rise (registered)
//   held          debounced level high and synchronized sample still high
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse,
    output logic held
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1, sync2;
    logic       level;
    logic [7:0] cnt;
    logic       differ;
    logic       accept;

    assign differ = (sync2 != level);
    assign accept = differ && (cnt == CNT_LAST);
    assign held   = level & sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= 8'd0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any sample equal to the current level restarts the count.
            if (!differ || accept) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
            if (accept) begin
                level <= sync2;
            end
            pulse <= accept & sync2;
        end
    end

endmodule

// File: rtl/timekeeper_ctrl.sv
// timekeeper_ctrl: mode FSM, 1 Hz prescaler and hh:mm:ss register file.
// RUN counts time from the prescaler tick; SET_SEC/SET_MIN/SET_HOUR freeze
// the prescaler and let the increment button bump the selected field.
// Optional feature macro: TIMEKEEPER_AUTOREPEAT_EN (increment auto-repeat
// while the button is held in a set mode, period REPEAT_CYCLES).
// Ports:
//   clock, reset       clock and asynchronous active-high reset
//   counter_trigger    raw mode button
//   increment_trigger  raw increment button
//   led_output         {hours, minutes, seconds}, 6 bits each, binary
//   mode_led_output    high whenever mode is not RUN
//   mode               current mode code
//   tick               one-cycle pulse per applied second tick
module timekeeper_ctrl
    import timekeeper_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 1000,
`ifdef TIMEKEEPER_AUTOREPEAT_EN
    parameter int unsigned REPEAT_CYCLES   = 500,
`endif
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             counter_trigger,
    input  logic             increment_trigger,
    output logic [LED_W-1:0] led_output,
    output logic             mode_led_output,
    output logic [1:0]       mode,
    output logic             tick
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic mode_pulse, mode_held;
    logic inc_pulse, inc_held;
    logic inc_req;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_btn (
        .clock(clock),
        .reset(reset),
        .raw  (counter_trigger),
        .pulse(mode_pulse),
        .held (mode_held)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_inc_btn (
        .clock(clock),
        .reset(reset),
        .raw  (increment_trigger),
        .pulse(inc_pulse),
        .held (inc_held)
    );

    mode_t              mode_q, mode_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [FIELD_W-1:0] sec_q, sec_d;
    logic [FIELD_W-1:0] min_q, min_d;
    logic [FIELD_W-1:0] hour_q, hour_d;
    logic               tick_q, tick_d;

`ifdef TIMEKEEPER_AUTOREPEAT_EN
    localparam int unsigned   RW       = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          rep_fire;
    logic          unused_held;

    assign unused_held = mode_held;
    assign rep_fire    = inc_held && (mode_q != MODE_RUN) && (rep_q == REP_LAST);
    assign inc_req     = inc_pulse | rep_fire;

    // Counts cycles of a sustained press; restarts on release or mode change.
    always_comb begin
        rep_d = rep_q + RW'(1);
        if (!inc_held || (mode_q == MODE_RUN) || mode_pulse || rep_fire) begin
            rep_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    logic unused_held;

    assign unused_held = mode_held ^ inc_held;
    assign inc_req     = inc_pulse;
`endif

    always_comb begin
        mode_d  = mode_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        tick_d  = 1'b0;

        if (mode_q == MODE_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                sec_d   = wrap_inc(sec_q, SEC_MAX);
                if (sec_q == SEC_MAX) begin
                    min_d = wrap_inc(min_q, MIN_MAX);
                    if (min_q == MIN_MAX) begin
                        hour_d = wrap_inc(hour_q, HOUR_MAX);
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            // Frozen at zero so RUN re-entry yields a full TICK_DIV period.
            presc_d = '0;
            if (inc_req) begin
                unique case (mode_q)
                    MODE_SET_SEC:  sec_d  = wrap_inc(sec_q, SEC_MAX);
                    MODE_SET_MIN:  min_d  = wrap_inc(min_q, MIN_MAX);
                    MODE_SET_HOUR: hour_d = wrap_inc(hour_q, HOUR_MAX);
                    default:       ;
                endcase
            end
        end

        // Increment above uses the pre-advance mode when both pulses coincide.
        if (mode_pulse) begin
            mode_d = mode_q + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_RUN;
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            tick_q  <= tick_d;
        end
    end

    assign led_output      = {hour_q, min_q, sec_q};
    assign mode            = mode_q;
    assign mode_led_output = (mode_q != MODE_RUN);
    assign tick            = tick_q;

endmodule

// File: tb/tb_timekeeper_ctrl.sv
// Bench for timekeeper_ctrl: table of button/wait steps with expected
// outputs, plus directed sequences for rollover, coincident pulses,
// glitches, reset during debounce and held-button behaviour.
module tb_timekeeper_ctrl;

    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned DEB      = 4;
    localparam int unsigned REP      = 20;
    localparam int unsigned HOLD     = 100;
`ifdef TIMEKEEPER_AUTOREPEAT_EN
    localparam int unsigned EXP_H = 1 + (HOLD - 2 - DEB) / REP;
`else
    localparam int unsigned EXP_H = 1;
`endif

    localparam int OP_MODE = 0;
    localparam int OP_INC  = 1;
    localparam int OP_WAIT = 2;

    typedef struct {
        int          op;
        int          n;
        logic [17:0] led;
        logic [1:0]  mode;
        logic        mode_led;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        counter_trigger = 1'b0;
    logic        increment_trigger = 1'b0;
    logic [17:0] led_output;
    logic        mode_led_output;
    logic [1:0]  mode;
    logic        tick;

    int checks = 0;
    int failures = 0;
    int tick_total = 0;
    int base;
    vec_t vecs[9];

    timekeeper_ctrl #(
        .TICK_DIV       (TICK_DIV),
`ifdef TIMEKEEPER_AUTOREPEAT_EN
        .REPEAT_CYCLES  (REP),
`endif
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock            (clk),
        .reset            (rst),
        .counter_trigger  (counter_trigger),
        .increment_trigger(increment_trigger),
        .led_output       (led_output),
        .mode_led_output  (mode_led_output),
        .mode             (mode),
        .tick             (tick)
    );

    always #5 clk = ~clk;

    // Tick pulses are counted 1 time unit after each edge.
    always @(posedge clk) begin
        #1;
        if (tick === 1'b1) tick_total++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges; return 2 time units after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input bit is_inc, input int n);
        for (int i = 0; i < n; i++) begin
            if (is_inc) increment_trigger = 1'b1;
            else counter_trigger = 1'b1;
            step(DEB + 4);
            increment_trigger = 1'b0;
            counter_trigger = 1'b0;
            step(DEB + 4);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{OP_MODE, 1, 18'd0,    2'd1, 1'b1};
        vecs[1] = '{OP_INC,  3, 18'd3,    2'd1, 1'b1};
        vecs[2] = '{OP_WAIT, 200, 18'd3,  2'd1, 1'b1};
        vecs[3] = '{OP_MODE, 1, 18'd3,    2'd2, 1'b1};
        vecs[4] = '{OP_INC,  1, 18'd67,   2'd2, 1'b1};
        vecs[5] = '{OP_MODE, 1, 18'd67,   2'd3, 1'b1};
        vecs[6] = '{OP_INC,  1, 18'd4163, 2'd3, 1'b1};
        vecs[7] = '{OP_MODE, 1, 18'd4163, 2'd0, 1'b0};
        vecs[8] = '{OP_WAIT, 10, 18'd4164, 2'd0, 1'b0};

        // Reset values, then 600 cycles of free running.
        step(2);
        check("reset led", led_output, 0);
        check("reset mode", mode, 0);
        check("reset mode_led", mode_led_output, 0);
        check("reset tick", tick, 0);
        rst = 1'b0;
        base = tick_total;
        step(600);
        check("run600 led", led_output, 18'd64);
        check("run600 ticks", tick_total - base, 60);
        check("run600 mode_led", mode_led_output, 0);

        // Table-driven set/run sequence.
        reset_dut();
        base = tick_total;
        for (int i = 0; i < 9; i++) begin
            case (vecs[i].op)
                OP_MODE: press(1'b0, vecs[i].n);
                OP_INC:  press(1'b1, vecs[i].n);
                default: step(vecs[i].n);
            endcase
            check($sformatf("vec%0d led", i), led_output, vecs[i].led);
            check($sformatf("vec%0d mode", i), mode, vecs[i].mode);
            check($sformatf("vec%0d mode_led", i), mode_led_output, vecs[i].mode_led);
            if (i == 2) check("set-mode ticks", tick_total - base, 0);
        end
        check("table ticks", tick_total - base, 1);

        // Preload 23:59:59 with field wraps, then full rollover.
        reset_dut();
        base = tick_total;
        press(1'b0, 1);
        press(1'b1, 59);
        check("sec 59", led_output, 18'd59);
        press(1'b0, 1);
        press(1'b1, 59);
        check("min 59", led_output, 18'd3835);
        press(1'b1, 1);
        check("min wrap no carry", led_output, 18'd59);
        press(1'b1, 59);
        press(1'b0, 1);
        press(1'b1, 23);
        check("hour 23", led_output, 18'd98043);
        press(1'b1, 1);
        check("hour wrap", led_output, 18'd3835);
        press(1'b1, 23);
        press(1'b0, 1);
        check("pre-roll led", led_output, 18'd98043);
        check("pre-roll mode", mode, 0);
        check("pre-roll ticks", tick_total - base, 0);
        step(1);
        check("rollover led", led_output, 0);
        check("rollover tick", tick, 1);
        step(1);
        check("rollover tick single", tick, 0);

        // Coincident mode and increment pulses in SET_SEC.
        reset_dut();
        base = tick_total;
        press(1'b0, 1);
        counter_trigger = 1'b1;
        increment_trigger = 1'b1;
        step(DEB + 4);
        counter_trigger = 1'b0;
        increment_trigger = 1'b0;
        step(DEB + 4);
        check("same-cycle led", led_output, 18'd1);
        check("same-cycle mode", mode, 2);

        // Glitch one sample short of acceptance.
        increment_trigger = 1'b1;
        step(DEB - 1);
        increment_trigger = 1'b0;
        step(16);
        check("glitch led", led_output, 18'd1);
        press(1'b1, 1);
        check("post-glitch led", led_output, 18'd65);
        check("set ticks", tick_total - base, 0);

        // Reset mid-debounce; button held through release is a fresh press.
        counter_trigger = 1'b1;
        step(3);
        rst = 1'b1;
        #1;
        check("mid-reset led", led_output, 0);
        check("mid-reset mode", mode, 0);
        check("mid-reset mode_led", mode_led_output, 0);
        check("mid-reset tick", tick, 0);
        step(3);
        rst = 1'b0;
        step(2 + DEB);
        check("held-reset mode early", mode, 0);
        step(1);
        check("held-reset mode", mode, 1);
        check("held-reset mode_led", mode_led_output, 1);
        counter_trigger = 1'b0;
        step(16);

        // Long increment hold in SET_HOUR.
        press(1'b0, 2);
        check("hold mode", mode, 3);
        increment_trigger = 1'b1;
        step(HOLD);
        increment_trigger = 1'b0;
        step(20);
        check("hold hours", led_output, EXP_H << 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
